// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control unit.
//   state_t        : controller FSM states
//   OP_*           : opcode values (zero-extended to OP_W at use)
//   ALU_*          : ALU function codes (zero-extended to FN_W at use)
//   SRCB_/PCSRC_/DST_* : datapath mux select encodings
//   FAULT_*        : fault_code values
package mc_pkg;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_WB_R,
    ST_EXEC_I,
    ST_WB_I,
    ST_MEM_ADDR,
    ST_MEM_RD,
    ST_MEM_WB,
    ST_MEM_WR,
    ST_BR_ADDR,
    ST_BR_CMP,
    ST_JUMP,
    ST_JAL_EX,
    ST_JAL_WB,
    ST_FAULT
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] ALU_ADD = 6'h20;
  localparam logic [5:0] ALU_SUB = 6'h22;
  localparam logic [5:0] ALU_XOR = 6'h26;

  localparam logic [1:0] SRCB_ONE = 2'd0;
  localparam logic [1:0] SRCB_B   = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;

  localparam logic [1:0] PCSRC_CONCAT = 2'd0;
  localparam logic [1:0] PCSRC_ALU    = 2'd1;
  localparam logic [1:0] PCSRC_ALUREG = 2'd2;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_TIMEOUT = 2'd1;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd2;

  // States that stall on the memory handshake and feed the watchdog.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_control_if.sv
// Controller <-> datapath bundle.
//   master : controller side (takes IR fields/flags/mem_ready, drives enables,
//            selects, ALU_OP and the fault/retired status)
//   slave  : datapath/memory side
interface mc_control_if #(
  parameter int unsigned OP_W  = 6,
  parameter int unsigned FN_W  = 6,
  parameter int unsigned CNT_W = 32
);
  logic [OP_W-1:0]  opcode;
  logic [FN_W-1:0]  funct;
  logic             zeroflag;
  logic             mem_ready;

  logic             PC_WE;
  logic             IR_WE;
  logic             MEM_WE;
  logic             MEM_IN;
  logic             ALU_SRCA;
  logic             REG_WE;
  logic             REG_IN;
  logic             CONCAT_WE;
  logic             SE_WE;
  logic [1:0]       ALU_SRCB;
  logic [1:0]       PC_SRC;
  logic [1:0]       DST;
  logic [FN_W-1:0]  ALU_OP;
  logic             fault;
  logic [1:0]       fault_code;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, funct, zeroflag, mem_ready,
    output PC_WE, IR_WE, MEM_WE, MEM_IN, ALU_SRCA, REG_WE, REG_IN,
           CONCAT_WE, SE_WE, ALU_SRCB, PC_SRC, DST, ALU_OP,
           fault, fault_code, retired
  );

  modport slave (
    output opcode, funct, zeroflag, mem_ready,
    input  PC_WE, IR_WE, MEM_WE, MEM_IN, ALU_SRCA, REG_WE, REG_IN,
           CONCAT_WE, SE_WE, ALU_SRCB, PC_SRC, DST, ALU_OP,
           fault, fault_code, retired
  );
endinterface

// File: rtl/mc_watchdog.sv
// Memory-handshake watchdog.
//   clk, rst_n : clock, async active-low reset
//   wait_c     : this cycle is a stalled memory cycle
//   expire_c   : this stalled cycle is the TIMEOUT-th in a row (0 disables)
module mc_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wait_c,
  output logic expire_c
);

  localparam int unsigned W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  // Completed stalled cycles so far; the current one is cnt + 1.
  logic [W-1:0] cnt;

  assign expire_c = (TIMEOUT != 0) && wait_c && (cnt == LAST);

  // Consecutive-stall counter; any non-stalled cycle clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (wait_c && !expire_c) begin
      cnt <= cnt + W'(1);
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle control unit for the single-memory MIPS-subset core.
//   clk, rst_n : clock, async active-low reset
//   bus        : IR opcode/funct, zeroflag, mem_ready in; all datapath enables,
//                mux selects, ALU_OP, sticky fault/fault_code and retired out
// Enables and selects are decoded from state; PC_WE/IR_WE in FETCH and PC_WE
// in BR_CMP additionally follow mem_ready / zeroflag.
module mc_control
  import mc_pkg::*;
#(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned FN_W    = 6,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  mc_control_if.master bus
);

  state_t           state;
  state_t           state_next;
  logic             wait_c;
  logic             expire_c;
  logic [1:0]       fault_set_c;
  logic [1:0]       fault_code_q;
  logic [CNT_W-1:0] retired_q;

  logic is_r, is_j, is_jal, is_beq, is_bne, is_addi, is_xori, is_lw, is_sw;

  assign is_r    = (bus.opcode == OP_W'(OP_R));
  assign is_j    = (bus.opcode == OP_W'(OP_J));
  assign is_jal  = (bus.opcode == OP_W'(OP_JAL));
  assign is_beq  = (bus.opcode == OP_W'(OP_BEQ));
  assign is_bne  = (bus.opcode == OP_W'(OP_BNE));
  assign is_addi = (bus.opcode == OP_W'(OP_ADDI));
  assign is_xori = (bus.opcode == OP_W'(OP_XORI));
  assign is_lw   = (bus.opcode == OP_W'(OP_LW));
  assign is_sw   = (bus.opcode == OP_W'(OP_SW));

  assign wait_c = is_wait_state(state) && !bus.mem_ready;

  mc_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .wait_c   (wait_c),
    .expire_c (expire_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state and Moore-decoded datapath controls.
  always_comb begin
    state_next    = state;
    fault_set_c   = FAULT_NONE;
    bus.PC_WE     = 1'b0;
    bus.IR_WE     = 1'b0;
    bus.MEM_WE    = 1'b0;
    bus.MEM_IN    = 1'b0;
    bus.ALU_SRCA  = 1'b0;
    bus.REG_WE    = 1'b0;
    bus.REG_IN    = 1'b0;
    bus.CONCAT_WE = 1'b0;
    bus.SE_WE     = 1'b0;
    bus.ALU_SRCB  = SRCB_ONE;
    bus.PC_SRC    = PCSRC_CONCAT;
    bus.DST       = DST_RT;
    bus.ALU_OP    = '0;
    bus.fault     = 1'b0;

    case (state)
      ST_IDLE: state_next = ST_FETCH;
      ST_FETCH: begin
        bus.MEM_IN   = 1'b1;
        bus.ALU_SRCA = 1'b1;
        bus.ALU_SRCB = SRCB_ONE;
        bus.ALU_OP   = FN_W'(ALU_ADD);
        bus.PC_SRC   = PCSRC_ALU;
        bus.IR_WE    = bus.mem_ready;
        bus.PC_WE    = bus.mem_ready;
        if (bus.mem_ready) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        bus.CONCAT_WE = 1'b1;
        bus.SE_WE     = 1'b1;
        if (is_r)                    state_next = ST_EXEC_R;
        else if (is_addi || is_xori) state_next = ST_EXEC_I;
        else if (is_lw || is_sw)     state_next = ST_MEM_ADDR;
        else if (is_beq || is_bne)   state_next = ST_BR_ADDR;
        else if (is_j)               state_next = ST_JUMP;
        else if (is_jal)             state_next = ST_JAL_EX;
        else begin
          state_next  = ST_FAULT;
          fault_set_c = FAULT_ILLEGAL;
        end
      end
      ST_EXEC_R: begin
        bus.ALU_SRCB = SRCB_B;
        bus.ALU_OP   = bus.funct;
        state_next   = ST_WB_R;
      end
      ST_WB_R: begin
        bus.DST    = DST_RD;
        bus.REG_WE = 1'b1;
        state_next = ST_FETCH;
      end
      ST_EXEC_I: begin
        bus.ALU_SRCB = SRCB_IMM;
        bus.ALU_OP   = is_xori ? FN_W'(ALU_XOR) : FN_W'(ALU_ADD);
        state_next   = ST_WB_I;
      end
      ST_WB_I: begin
        bus.DST    = DST_RT;
        bus.REG_WE = 1'b1;
        state_next = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        bus.ALU_SRCB = SRCB_IMM;
        bus.ALU_OP   = FN_W'(ALU_ADD);
        state_next   = is_lw ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        bus.MEM_IN = 1'b0;
        if (bus.mem_ready) state_next = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        bus.REG_IN = 1'b1;
        bus.DST    = DST_RT;
        bus.REG_WE = 1'b1;
        state_next = ST_FETCH;
      end
      ST_MEM_WR: begin
        bus.MEM_WE = 1'b1;
        if (bus.mem_ready) state_next = ST_FETCH;
      end
      ST_BR_ADDR: begin
        bus.ALU_SRCA = 1'b1;
        bus.ALU_SRCB = SRCB_IMM;
        bus.ALU_OP   = FN_W'(ALU_ADD);
        state_next   = ST_BR_CMP;
      end
      ST_BR_CMP: begin
        bus.ALU_SRCB = SRCB_B;
        bus.ALU_OP   = FN_W'(ALU_SUB);
        bus.PC_SRC   = PCSRC_ALUREG;
        bus.PC_WE    = is_beq ? bus.zeroflag : !bus.zeroflag;
        state_next   = ST_FETCH;
      end
      ST_JUMP: begin
        bus.PC_SRC = PCSRC_CONCAT;
        bus.PC_WE  = 1'b1;
        state_next = ST_FETCH;
      end
      ST_JAL_EX: begin
        bus.ALU_SRCA = 1'b1;
        bus.ALU_SRCB = SRCB_ONE;
        bus.ALU_OP   = FN_W'(ALU_ADD);
        state_next   = ST_JAL_WB;
      end
      ST_JAL_WB: begin
        bus.DST    = DST_RA;
        bus.REG_WE = 1'b1;
        state_next = ST_JUMP;
      end
      ST_FAULT: bus.fault = 1'b1;
      default:  state_next = ST_IDLE;
    endcase

    // Watchdog expiry overrides the stall and suppresses every write enable.
    if (expire_c) begin
      state_next  = ST_FAULT;
      fault_set_c = FAULT_TIMEOUT;
      bus.PC_WE   = 1'b0;
      bus.IR_WE   = 1'b0;
      bus.MEM_WE  = 1'b0;
    end
  end

  // Sticky fault cause, captured on entry to FAULT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         fault_code_q <= FAULT_NONE;
    else if (fault_set_c != FAULT_NONE) fault_code_q <= fault_set_c;
  end

  // Retired count: every return to FETCH except the first one out of IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else if (state_next == ST_FETCH && state != ST_IDLE && state != ST_FETCH) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.fault_code = fault_code_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: per-instruction expected control traces
// are generated from the instruction semantics and compared cycle by cycle.
module tb_mc_control;

  localparam int unsigned T = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mc_control_if #(.OP_W(6), .FN_W(6), .CNT_W(32)) bus_if ();

  mc_control #(.OP_W(6), .FN_W(6), .CNT_W(32), .TIMEOUT(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct packed {
    logic       fault;
    logic [1:0] code;
    logic       pc_we, ir_we, mem_we, mem_in, srca, reg_we, reg_in, concat_we, se_we;
    logic [1:0] srcb, pcsrc, dst;
    logic [5:0] alu;
  } ov_t;

  typedef struct {
    logic mr;
    ov_t  v;
  } cyc_t;

  cyc_t        exp_q[$];
  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] retired_m = '0;
  bit          mr_hold = 1'b0;

  function automatic ov_t get_obs();
    ov_t o;
    o.fault     = bus_if.fault;
    o.code      = bus_if.fault_code;
    o.pc_we     = bus_if.PC_WE;
    o.ir_we     = bus_if.IR_WE;
    o.mem_we    = bus_if.MEM_WE;
    o.mem_in    = bus_if.MEM_IN;
    o.srca      = bus_if.ALU_SRCA;
    o.reg_we    = bus_if.REG_WE;
    o.reg_in    = bus_if.REG_IN;
    o.concat_we = bus_if.CONCAT_WE;
    o.se_we     = bus_if.SE_WE;
    o.srcb      = bus_if.ALU_SRCB;
    o.pcsrc     = bus_if.PC_SRC;
    o.dst       = bus_if.DST;
    o.alu       = bus_if.ALU_OP;
    return o;
  endfunction

  function automatic void push(ov_t v, logic mr);
    cyc_t c;
    c.v  = v;
    c.mr = mr;
    exp_q.push_back(c);
  endfunction

  // Cycles that ignore mem_ready get a random level unless it is held high.
  function automatic void push_any(ov_t v);
    push(v, mr_hold ? 1'b1 : 1'($urandom));
  endfunction

  // n stalled cycles then a ready one; the T-th stall becomes the expiry cycle.
  function automatic bit add_wait(ov_t w, ov_t done, ov_t expire, int n);
    for (int i = 0; i < n; i++) begin
      if (i == int'(T) - 1) begin
        push(expire, 1'b0);
        return 1'b0;
      end
      push(w, 1'b0);
    end
    push(done, 1'b1);
    return 1'b1;
  endfunction

  function automatic void add_fault(logic [1:0] code);
    ov_t o;
    o = '0;
    o.fault = 1'b1;
    o.code  = code;
    for (int i = 0; i < 3; i++) push(o, 1'($urandom));
  endfunction

  function automatic bit is_legal(logic [5:0] op);
    case (op)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0E, 6'h23, 6'h2B: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected trace of one instruction from FETCH on; returns 1 if it retires.
  function automatic bit build(logic [5:0] op, logic [5:0] fn, bit zf, int wf, int wm);
    ov_t o, w, d, e;
    w = '0; w.mem_in = 1'b1; w.srca = 1'b1; w.alu = 6'h20; w.pcsrc = 2'd1;
    d = w;  d.pc_we = 1'b1; d.ir_we = 1'b1;
    if (!add_wait(w, d, w, wf)) begin add_fault(2'd1); return 1'b0; end
    o = '0; o.concat_we = 1'b1; o.se_we = 1'b1; push_any(o);
    case (op)
      6'h00: begin
        o = '0; o.srcb = 2'd1; o.alu = fn; push_any(o);
        o = '0; o.dst = 2'd1; o.reg_we = 1'b1; push_any(o);
      end
      6'h08, 6'h0E: begin
        o = '0; o.srcb = 2'd2; o.alu = (op == 6'h0E) ? 6'h26 : 6'h20; push_any(o);
        o = '0; o.reg_we = 1'b1; push_any(o);
      end
      6'h23: begin
        o = '0; o.srcb = 2'd2; o.alu = 6'h20; push_any(o);
        w = '0;
        if (!add_wait(w, w, w, wm)) begin add_fault(2'd1); return 1'b0; end
        o = '0; o.reg_in = 1'b1; o.reg_we = 1'b1; push_any(o);
      end
      6'h2B: begin
        o = '0; o.srcb = 2'd2; o.alu = 6'h20; push_any(o);
        w = '0; w.mem_we = 1'b1; e = '0;
        if (!add_wait(w, w, e, wm)) begin add_fault(2'd1); return 1'b0; end
      end
      6'h04, 6'h05: begin
        o = '0; o.srca = 1'b1; o.srcb = 2'd2; o.alu = 6'h20; push_any(o);
        o = '0; o.srcb = 2'd1; o.alu = 6'h22; o.pcsrc = 2'd2;
        o.pc_we = (op == 6'h04) ? zf : !zf; push_any(o);
      end
      6'h02: begin
        o = '0; o.pc_we = 1'b1; push_any(o);
      end
      6'h03: begin
        o = '0; o.srca = 1'b1; o.alu = 6'h20; push_any(o);
        o = '0; o.dst = 2'd2; o.reg_we = 1'b1; push_any(o);
        o = '0; o.pc_we = 1'b1; push_any(o);
      end
      default: begin
        add_fault(2'd2);
        return 1'b0;
      end
    endcase
    return 1'b1;
  endfunction

  // Entered at posedge+1 of the first expected cycle; leaves at posedge+1 after the last.
  task automatic run_q(string name, int limit);
    int   n;
    cyc_t c;
    ov_t  obs;
    n = exp_q.size();
    if (limit >= 0 && limit < n) n = limit;
    for (int i = 0; i < n; i++) begin
      c = exp_q[i];
      bus_if.mem_ready = c.mr;
      @(negedge clk);
      obs = get_obs();
      vectors++;
      if (obs !== c.v) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h want %h", name, i, obs, c.v);
      end
      @(posedge clk);
      #1;
    end
    exp_q.delete();
  endtask

  task automatic do_instr(string name, logic [5:0] op, logic [5:0] fn, bit zf, int wf, int wm);
    bit ok;
    bus_if.opcode   = op;
    bus_if.funct    = fn;
    bus_if.zeroflag = zf;
    ok = build(op, fn, zf, wf, wm);
    run_q(name, -1);
    if (ok) retired_m++;
    vectors++;
    if (bus_if.retired !== retired_m) begin
      errors++;
      $display("FAIL %s retired: got %0d want %0d", name, bus_if.retired, retired_m);
    end
  endtask

  // Reset, check all-zero outputs, release so the next cycle is IDLE, end in FETCH.
  task automatic do_reset(string name);
    rst_n = 1'b0;
    bus_if.mem_ready = 1'($urandom);
    #3;
    vectors++;
    if (get_obs() !== ov_t'(0) || bus_if.retired !== 32'd0) begin
      errors++;
      $display("FAIL %s in_reset: got %h retired %0d want 0", name, get_obs(), bus_if.retired);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus_if.mem_ready = 1'($urandom);
    @(negedge clk);
    vectors++;
    if (get_obs() !== ov_t'(0)) begin
      errors++;
      $display("FAIL %s idle: got %h want 0", name, get_obs());
    end
    @(posedge clk);
    #1;
    retired_m = '0;
  endtask

  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_reset_mid_write();
    do_instr("pre_addi", 6'h08, 6'h00, 1'b0, 1, 0);
    bus_if.opcode = 6'h2B;
    void'(build(6'h2B, 6'h00, 1'b0, 0, 3));
    run_q("sw_abort", 4);
    bus_if.mem_ready = 1'b0;
    #2;
    vectors++;
    if (bus_if.MEM_WE !== 1'b1) begin
      errors++;
      $display("FAIL sw_abort mem_we_before: got %b want 1", bus_if.MEM_WE);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (get_obs() !== ov_t'(0) || bus_if.retired !== 32'd0) begin
      errors++;
      $display("FAIL sw_abort async: got %h retired %0d want 0", get_obs(), bus_if.retired);
    end
    do_reset("sw_abort_release");
  endtask

  task automatic test_addi_r();
    mr_hold = 1'b1;
    do_instr("addi", 6'h08, 6'h00, 1'b0, 0, 0);
    do_instr("r_add", 6'h00, 6'h20, 1'b0, 0, 0);
    mr_hold = 1'b0;
    vectors++;
    if (bus_if.retired !== 32'd2) begin
      errors++;
      $display("FAIL addi_r retired: got %0d want 2", bus_if.retired);
    end
  endtask

  task automatic test_lw_wait();
    do_instr("lw_wait3", 6'h23, 6'h00, 1'b0, 0, 3);
    do_instr("sw_wait3", 6'h2B, 6'h00, 1'b0, 3, 3);
    do_instr("xori", 6'h0E, 6'h00, 1'b1, 2, 0);
  endtask

  task automatic test_branch();
    do_instr("beq_z1", 6'h04, 6'h00, 1'b1, 0, 0);
    do_instr("bne_z1", 6'h05, 6'h00, 1'b1, 0, 0);
    do_instr("beq_z0", 6'h04, 6'h00, 1'b0, 1, 0);
    do_instr("bne_z0", 6'h05, 6'h00, 1'b0, 1, 0);
  endtask

  task automatic test_jal();
    do_instr("jal", 6'h03, 6'h00, 1'b0, 0, 0);
    do_instr("j", 6'h02, 6'h00, 1'b1, 2, 0);
  endtask

  task automatic test_random();
    logic [5:0] op, fn;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 8))
        0: op = 6'h00;  1: op = 6'h02;  2: op = 6'h03;
        3: op = 6'h04;  4: op = 6'h05;  5: op = 6'h08;
        6: op = 6'h0E;  7: op = 6'h23;  default: op = 6'h2B;
      endcase
      case ($urandom_range(0, 3))
        0: fn = 6'h20;  1: fn = 6'h22;  2: fn = 6'h26;
        default: fn = 6'($urandom);
      endcase
      do_instr($sformatf("rand%0d_op%h", k, op), op, fn, 1'($urandom),
               int'($urandom_range(0, T - 1)), int'($urandom_range(0, T - 1)));
    end
  endtask

  task automatic test_timeout();
    do_instr("fetch_timeout", 6'h08, 6'h00, 1'b0, 4, 0);
    do_reset("after_fetch_timeout");
    do_instr("sw_timeout", 6'h2B, 6'h00, 1'b0, 0, 6);
    do_reset("after_sw_timeout");
    do_instr("lw_timeout", 6'h23, 6'h00, 1'b0, 1, 4);
    do_reset("after_lw_timeout");
  endtask

  task automatic test_illegal();
    logic [5:0] op;
    do_instr("illegal_3f", 6'h3F, 6'h00, 1'b0, 0, 0);
    do_reset("after_illegal_3f");
    do op = 6'($urandom); while (is_legal(op));
    do_instr($sformatf("illegal_%h", op), op, 6'h00, 1'b0, 1, 0);
    do_reset("after_illegal_rand");
  endtask

  initial begin
    rst_n            = 1'b0;
    bus_if.opcode    = '0;
    bus_if.funct     = '0;
    bus_if.zeroflag  = 1'b0;
    bus_if.mem_ready = 1'b0;
    test_reset();
    test_reset_mid_write();
    test_addi_r();
    test_lw_wait();
    test_branch();
    test_jal();
    test_random();
    test_timeout();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
